// File: rtl/q3_pkg.sv
// Shared constants and helpers for the q3 input conditioner.
// Holds the default channel count and debounce counter sizing.
package q3_pkg;

  localparam int unsigned Q3_WIDTH = 8;
  localparam int unsigned Q3_DBNC_DEFAULT = 4;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  localparam int unsigned DBNC_CNT_W = cnt_width(Q3_DBNC_DEFAULT);

  typedef logic [DBNC_CNT_W-1:0] dbnc_cnt_t;

endpackage

// File: rtl/q3_debounce_channel.sv
// One input bit: synchroniser, debounce counter, clean level, edge pulses.
// The sync chain shifts every cycle; everything else holds while ena_i is low.
module q3_debounce_channel
  import q3_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ena_i,
  input  logic tick_i,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   clean_q;
  logic                   clean_d;
  logic                   rise_q;
  logic                   rise_d;
  logic                   fall_q;
  logic                   fall_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  // Agreement clears the count on every enabled cycle, tick or not.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (ena_i) begin
      if (synced == clean_q) begin
        cnt_d = '0;
      end else if (tick_i) begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          clean_d = ~clean_q;
          rise_d  = ~clean_q;
          fall_d  = clean_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/q3_input_conditioner.sv
// Pad front-end for tt_um_q3: per-bit sync, debounce and edge pulses.
// Optional shared debounce prescaler when DBNC_PRESCALE_EN is defined.
module q3_input_conditioner
  import q3_pkg::*;
#(
  parameter int unsigned WIDTH           = Q3_WIDTH,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PRESCALE_LOG2   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || PRESCALE_LOG2 < 1) begin : g_bad_param
    $error("q3_input_conditioner: illegal parameter value");
  end

  logic tick;

`ifdef DBNC_PRESCALE_EN
  logic [PRESCALE_LOG2-1:0] pre_q;
  logic [PRESCALE_LOG2-1:0] pre_d;

  // Free-running while enabled; parked at zero while disabled.
  always_comb begin
    pre_d = '0;
    if (ena) pre_d = pre_q + PRESCALE_LOG2'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign tick = ena && (pre_q == '1);
`else
  assign tick = 1'b1;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    q3_debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .ena_i  (ena),
      .tick_i (tick),
      .raw_i  (raw_in[i]),
      .clean_o(clean_out[i]),
      .rise_o (rise_pulse[i]),
      .fall_o (fall_pulse[i])
    );
  end

endmodule

// File: doc/q3_input_conditioner.md
Name: q3_input_conditioner

Overview:
Input front-end for tt_um_q3. Sits between the raw ui_in pads and the q3 core logic.
Per bit it synchronises the asynchronous pad input, debounces it, and emits one-cycle rise/fall pulses.
The core consumes clean levels and edge pulses only.

Parameters:
WIDTH, 8, number of input channels (matches ui_in).
SYNC_STAGES, 2, synchroniser flop depth; must be >= 2.
DEBOUNCE_CYCLES, 4, consecutive disagreeing samples required before clean level flips; must be >= 1.
PRESCALE_LOG2, 4, prescaler exponent; used only when DBNC_PRESCALE_EN is defined.

Ports:
clk  input  1  system clock (TT clk)
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; low freezes all state
raw_in  input  WIDTH  asynchronous pad levels (ui_in)
clean_out  output  WIDTH  debounced level per channel
rise_pulse  output  WIDTH  one-cycle pulse on clean 0->1
fall_pulse  output  WIDTH  one-cycle pulse on clean 1->0

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. All flops clear on rst_n low regardless of ena.
- Reset values:
  - sync chain, counters, clean_out, rise_pulse and fall_pulse are all 0.
  - Any in-progress count is discarded; a mid-operation reset fully restarts debounce.
- Synchroniser: SYNC_STAGES-deep flop chain per bit. The last stage is "synced". The chain shifts every cycle, ignoring ena, to avoid metastable holds.
- Per-channel counter: width clog2(DEBOUNCE_CYCLES), minimum 1 bit. Per cycle with ena=1:
  - synced == clean: counter <= 0.
  - synced != clean and counter < DEBOUNCE_CYCLES-1: counter++.
  - synced != clean and counter == DEBOUNCE_CYCLES-1: clean toggles, counter <= 0, and the matching pulse asserts.
- Pulses are registered. They assert in the same cycle clean_out changes and are high for exactly one cycle. rise and fall are never both high on one bit.
- Latency: a raw step held steadily changes clean_out SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples it. Defaults give 6.
- Glitch rejection:
  - A synced excursion shorter than DEBOUNCE_CYCLES cycles produces no change.
  - Any single agreeing sample resets the count.
- DEBOUNCE_CYCLES=1: clean follows synced with one extra cycle of delay.
- ena=0:
  - counters and clean_out hold;
  - pulses forced 0 next cycle;
  - a pulse pending at the ena fall is dropped;
  - counting resumes from the held count when ena returns.
- Channels are fully independent. Simultaneous changes on several bits produce simultaneous pulses.

Optional Feature:
- Macro DBNC_PRESCALE_EN.
- Defined: a shared free-running PRESCALE_LOG2-bit counter generates a tick every 2^PRESCALE_LOG2 cycles.
  - Channel counters increment, and clean toggles, only on tick cycles.
  - A counter reset on agreement still happens every cycle.
  - Latency becomes roughly DEBOUNCE_CYCLES * 2^PRESCALE_LOG2. The prescaler resets to 0 and freezes while ena=0.
- Undefined: no prescaler logic; every cycle counts as a tick, exactly as in Behaviour.

Decomposition:
- Package q3_pkg holds:
  - the WIDTH default constant (8);
  - a clog2-style counter width helper;
  - the debounce counter width localparam type.
- One natural sub-module, q3_debounce_channel: one bit with sync chain, counter, clean flop and pulse flops. It is instantiated WIDTH times via generate.
- The prescaler stays in the top module.

Test Plan (defaults SYNC_STAGES=2, DEBOUNCE_CYCLES=4, macro undefined):
- Reset: hold rst_n=0 with raw_in=8'hFF and ena=1 -> clean_out=0, rise_pulse=0 and fall_pulse=0 throughout. Release -> clean_out=8'hFF after 6 edges, with rise_pulse=8'hFF for exactly 1 cycle.
- Step: raw_in[0] 0->1 held -> clean_out[0] rises on edge 6 and rise_pulse[0] is high one cycle. Then 1->0 -> fall_pulse[0] one cycle, 6 edges later.
- Glitch: raw_in[3] high for 3 cycles -> clean_out[3] stays 0 with no pulses. Repeat with 4 cycles -> rise then fall, each pulse one cycle.
- Freeze: start a step on bit 5, drop ena for 10 cycles after 2 counting edges -> no change while ena=0. clean_out[5] rises 2 counting edges after ena returns.
- Async reset mid-count: assert rst_n between edges during a bit-2 count -> outputs 0 immediately, with no pulse afterwards until a fresh full 6-edge qualification.
- Multi-bit: raw_in 8'h00 -> 8'hA5 in one step -> rise_pulse=8'hA5 in a single cycle and fall_pulse=0.
